vproc_div_seq: RTL and testbench
================================

VPROC_DIV_SEQ -- requirements
Module: vproc_div_seq

Interface
REQ-001 SHALL have parameter DIV_OP_W, default 64: vector operand width in bits; a multiple of 32 and at least 32.
REQ-002 SHALL have parameter CTRL_W, default 32: width of the opaque control word passed through unchanged.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 async_rst_i  in  1  asynchronous active-high reset.
REQ-006 in_valid_i  in  1  request valid.
REQ-007 in_ready_o  out  1  request accepted when high together with in_valid_i.
REQ-008 in_ctrl_i  in  CTRL_W  control word, captured at accept.
REQ-009 in_sew_i  in  2  element width: 00=8, 01=16, 10=32, 11=treated as 32.
REQ-010 in_op_i  in  2  operation: 00=DIVU, 01=DIV, 10=REMU, 11=REM.
REQ-011 in_op1_i  in  DIV_OP_W  divisor vector.
REQ-012 in_op2_i  in  DIV_OP_W  dividend vector.
REQ-013 in_mask_i  in  DIV_OP_W/8  byte mask.
REQ-014 in_masked_i  in  1  mask enable.
REQ-015 div_valid_o / div_ready_i  out/in  1/1  issue handshake to the shared 32-bit divider.
REQ-016 div_op_o  out  2  operation sent to the divider (in_op_i encoding).
REQ-017 div_opa_o  out  32  extended dividend sent to the divider.
REQ-018 div_opb_o  out  32  extended divisor sent to the divider.
REQ-019 div_res_valid_i / div_res_ready_o / div_res_i  in/out/in  1/1/32  divider result handshake and data.
REQ-020 out_valid_o / out_ready_i  out/in  1/1  result handshake.
REQ-021 out_ctrl_o  out  CTRL_W  captured control word.
REQ-022 out_res_o  out  DIV_OP_W  result vector.
REQ-023 out_mask_o  out  DIV_OP_W/8  result byte mask.

Function
REQ-024 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-025 in_ready_o SHALL be 1 only in IDLE; on accept it SHALL register ctrl, sew, op, both operands, the mask and the mask enable, clear the result register and element index, and go to ISSUE.
REQ-026 Element count SHALL be N = DIV_OP_W/SEW; element e SHALL occupy bits [e*SEW +: SEW].
REQ-027 Element e SHALL be skipped when in_masked_i=1 and mask bit e*SEW/8 is 0.
REQ-028 In ISSUE with the current element skipped: its result slot SHALL be 0, div_valid_o SHALL be 0, and the index SHALL advance after 1 cycle.
REQ-029 In ISSUE with the current element active: div_valid_o SHALL be 1, with div_opa_o/div_opb_o sign-extended (op 01, 11) or zero-extended (op 00, 10) to 32 bits.
REQ-030 div_opa_o, div_opb_o and div_op_o SHALL stay stable while div_valid_o=1 and div_ready_i=0; on the handshake the FSM SHALL go to WAIT.
REQ-031 In WAIT, div_res_ready_o SHALL be 1; when div_res_valid_i=1, div_res_i[SEW-1:0] SHALL be written to the current slot and the index SHALL advance.
REQ-032 After the last element (index N-1) completes or is skipped, the FSM SHALL go to DONE; otherwise it SHALL return to ISSUE.
REQ-033 Minimum issue latency per active element SHALL be 1 cycle.
REQ-034 In DONE, out_valid_o SHALL be 1, and out_res_o, out_ctrl_o and out_mask_o SHALL be held until out_ready_i=1; the FSM SHALL then go to IDLE the next cycle.
REQ-035 out_mask_o SHALL equal the captured mask when masked=1, else all ones.
REQ-036 Divide-by-zero and overflow SHALL NOT be special-cased; the divider result is used as-is.
REQ-037 div_res_valid_i outside WAIT SHALL be ignored.
REQ-038 in_valid_i outside IDLE SHALL be ignored.
REQ-039 The element index SHALL never exceed N-1.
REQ-040 When all elements are skipped, the block SHALL reach DONE after N cycles in ISSUE without asserting div_valid_o.

Reset
REQ-041 Asynchronous reset, at any time including mid-WAIT, SHALL force: IDLE, index 0, result register 0, in_ready_o=1 (once reset deasserts), div_valid_o=0, div_res_ready_o=0, out_valid_o=0, and out_res_o, out_mask_o, out_ctrl_o all 0.
REQ-042 The shared divider SHALL be reset by the same reset, so no stale result can be returned after reset.

Verification
REQ-043 DIV_OP_W=64, SEW32, DIVU, op2=0x00000064_0000000A, op1=0x00000005_00000003 -> exactly 2 divider issues (opa 0x0A then 0x64); out_res_o=0x00000014_00000003; out_mask_o=0xFF.
REQ-044 SEW8, DIV, byte0 dividend 0xF6 and divisor 0x03, all other bytes 0x01 -> first issue opa=0xFFFFFFF6, opb=0x00000003; out_res_o byte0=0xFD, other bytes 0x01; 8 issues.
REQ-045 SEW16, REMU, masked=1, mask=0x33 -> only elements 0 and 2 issued; slots 1 and 3 are 0; out_mask_o=0x33.
REQ-046 div_ready_i held low 5 cycles during ISSUE, then out_ready_i held low 3 cycles in DONE -> div_opa_o and out_res_o stable throughout; in_ready_o=0 until the cycle after the out handshake.
REQ-047 Reset asserted in WAIT, then a stray div_res_valid_i -> in_ready_o=1, div_valid_o=0, out_valid_o=0; the stray result is not captured.
REQ-048 masked=1, mask=0x00 -> zero divider issues; out_valid_o=1 after 2 cycles (SEW32); out_res_o=0; out_mask_o=0x00.

Source files
------------

// File: rtl/vproc_div_seq_if.sv
// rtl/vproc_div_seq_if.sv - request, divider and result handshake bundle for vproc_div_seq
//
// Purpose: groups the request, shared-divider and result handshakes of the
//          sequential vector divider into one interface.
// Signals:
//   in_*      request side (valid/ready, ctrl, sew, op, operands, mask)
//   div_*     issue and result handshakes to the shared 32-bit divider
//   out_*     result side (valid/ready, ctrl, result vector, byte mask)
// Modports:
//   slave     the divider sequencer (drives *_o, samples *_i)
//   master    the environment around it
interface vproc_div_seq_if #(
   parameter int DIV_OP_W = 64,
   parameter int CTRL_W   = 32
);
   logic                    in_valid_i;
   logic                    in_ready_o;
   logic [CTRL_W-1:0]       in_ctrl_i;
   logic [1:0]              in_sew_i;
   logic [1:0]              in_op_i;
   logic [DIV_OP_W-1:0]     in_op1_i;
   logic [DIV_OP_W-1:0]     in_op2_i;
   logic [DIV_OP_W/8-1:0]   in_mask_i;
   logic                    in_masked_i;

   logic                    div_valid_o;
   logic                    div_ready_i;
   logic [1:0]              div_op_o;
   logic [31:0]             div_opa_o;
   logic [31:0]             div_opb_o;
   logic                    div_res_valid_i;
   logic                    div_res_ready_o;
   logic [31:0]             div_res_i;

   logic                    out_valid_o;
   logic                    out_ready_i;
   logic [CTRL_W-1:0]       out_ctrl_o;
   logic [DIV_OP_W-1:0]     out_res_o;
   logic [DIV_OP_W/8-1:0]   out_mask_o;

   modport slave (
      input  in_valid_i, in_ctrl_i, in_sew_i, in_op_i, in_op1_i, in_op2_i,
             in_mask_i, in_masked_i, div_ready_i, div_res_valid_i, div_res_i,
             out_ready_i,
      output in_ready_o, div_valid_o, div_op_o, div_opa_o, div_opb_o,
             div_res_ready_o, out_valid_o, out_ctrl_o, out_res_o, out_mask_o
   );

   modport master (
      output in_valid_i, in_ctrl_i, in_sew_i, in_op_i, in_op1_i, in_op2_i,
             in_mask_i, in_masked_i, div_ready_i, div_res_valid_i, div_res_i,
             out_ready_i,
      input  in_ready_o, div_valid_o, div_op_o, div_opa_o, div_opb_o,
             div_res_ready_o, out_valid_o, out_ctrl_o, out_res_o, out_mask_o
   );
endinterface

// File: rtl/vproc_div_seq.sv
// rtl/vproc_div_seq.sv - sequential element-wise vector divider front end
//
// Purpose: accepts one vector divide request, walks its elements one at a
//          time through a shared 32-bit divider (skipping masked-off
//          elements) and returns the assembled result vector.
// Ports:
//   clk_i        clock, rising edge
//   async_rst_i  asynchronous active-high reset
//   bus          vproc_div_seq_if.slave: request, divider and result handshakes
module vproc_div_seq #(
   parameter int DIV_OP_W = 64,
   parameter int CTRL_W   = 32
) (
   input  logic            clk_i,
   input  logic            async_rst_i,
   vproc_div_seq_if.slave  bus
);
   localparam int NB    = DIV_OP_W / 8;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int BW    = IDX_W + 3;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [CTRL_W-1:0]   r_ctrl;
   logic [1:0]          r_sew_sh;   // log2(SEW/8); code 11 folded into 32-bit
   logic [1:0]          r_op;
   logic [DIV_OP_W-1:0] r_op1;
   logic [DIV_OP_W-1:0] r_op2;
   logic [NB-1:0]       r_mask;
   logic                r_masked;
   logic [DIV_OP_W-1:0] r_res;
   logic [NB-1:0]       r_out_mask;

   logic [BW-1:0]       w_base;
   logic [IDX_W-1:0]    w_last;
   logic                w_is_last;
   logic                w_active;
   logic [DIV_OP_W-1:0] w_a_sh;
   logic [DIV_OP_W-1:0] w_b_sh;
   logic [31:0]         w_a_raw;
   logic [31:0]         w_b_raw;
   logic [31:0]         w_opa;
   logic [31:0]         w_opb;
   logic [DIV_OP_W-1:0] w_slot_mask;
   logic [DIV_OP_W-1:0] w_res_slot;
   logic [DIV_OP_W-1:0] w_res_next;

   // Bit offset of the current element; its byte offset also selects the mask bit.
   assign w_base    = {r_idx, 3'b000} << r_sew_sh;
   assign w_last    = IDX_W'((NB >> r_sew_sh) - 1);
   assign w_is_last = (r_idx == w_last);
   assign w_active  = !r_masked || r_mask[w_base[BW-1:3]];

   // Shift instead of a part-select so narrow elements near the top never read past the vector.
   assign w_a_sh  = r_op2 >> w_base;
   assign w_b_sh  = r_op1 >> w_base;
   assign w_a_raw = w_a_sh[31:0];
   assign w_b_raw = w_b_sh[31:0];

   always_comb begin
      w_opa       = w_a_raw;
      w_opb       = w_b_raw;
      w_slot_mask = DIV_OP_W'(32'hFFFF_FFFF);
      case (r_sew_sh)
         2'd0: begin
            w_opa       = {{24{r_op[0] & w_a_raw[7]}}, w_a_raw[7:0]};
            w_opb       = {{24{r_op[0] & w_b_raw[7]}}, w_b_raw[7:0]};
            w_slot_mask = DIV_OP_W'(32'h0000_00FF);
         end
         2'd1: begin
            w_opa       = {{16{r_op[0] & w_a_raw[15]}}, w_a_raw[15:0]};
            w_opb       = {{16{r_op[0] & w_b_raw[15]}}, w_b_raw[15:0]};
            w_slot_mask = DIV_OP_W'(32'h0000_FFFF);
         end
         default: ;
      endcase
   end

   assign w_res_slot = (DIV_OP_W'(bus.div_res_i) & w_slot_mask) << w_base;
   assign w_res_next = (r_res & ~(w_slot_mask << w_base)) | w_res_slot;

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_ctrl     <= '0;
         r_sew_sh   <= '0;
         r_op       <= '0;
         r_op1      <= '0;
         r_op2      <= '0;
         r_mask     <= '0;
         r_masked   <= 1'b0;
         r_res      <= '0;
         r_out_mask <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid_i) begin
                  r_ctrl     <= bus.in_ctrl_i;
                  r_sew_sh   <= (bus.in_sew_i == 2'b11) ? 2'b10 : bus.in_sew_i;
                  r_op       <= bus.in_op_i;
                  r_op1      <= bus.in_op1_i;
                  r_op2      <= bus.in_op2_i;
                  r_mask     <= bus.in_mask_i;
                  r_masked   <= bus.in_masked_i;
                  r_out_mask <= bus.in_masked_i ? bus.in_mask_i : '1;
                  r_res      <= '0;
                  r_idx      <= '0;
                  r_state    <= ISSUE;
               end
            end
            ISSUE: begin
               // Skipped slots already hold 0 from the clear at accept.
               if (!w_active) begin
                  if (w_is_last) r_state <= DONE;
                  else           r_idx   <= r_idx + IDX_W'(1);
               end else if (bus.div_ready_i) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (bus.div_res_valid_i) begin
                  r_res <= w_res_next;
                  if (w_is_last) begin
                     r_state <= DONE;
                  end else begin
                     r_idx   <= r_idx + IDX_W'(1);
                     r_state <= ISSUE;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready_i) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready_o      = (r_state == IDLE);
   assign bus.div_valid_o     = (r_state == ISSUE) && w_active;
   assign bus.div_op_o        = r_op;
   assign bus.div_opa_o       = w_opa;
   assign bus.div_opb_o       = w_opb;
   assign bus.div_res_ready_o = (r_state == WAIT);
   assign bus.out_valid_o     = (r_state == DONE);
   assign bus.out_ctrl_o      = r_ctrl;
   assign bus.out_res_o       = r_res;
   assign bus.out_mask_o      = r_out_mask;
endmodule

// File: tb/tb_vproc_div_seq.sv
// tb/tb_vproc_div_seq.sv - scoreboard testbench for vproc_div_seq
module tb_vproc_div_seq;
   localparam int W  = 64;
   localparam int CW = 32;
   localparam int NB = W / 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vproc_div_seq_if #(.DIV_OP_W(W), .CTRL_W(CW)) bus ();
   vproc_div_seq #(.DIV_OP_W(W), .CTRL_W(CW)) dut (
      .clk_i       (clk),
      .async_rst_i (rst),
      .bus         (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0]  res;
      logic [NB-1:0] mask;
      logic [CW-1:0] ctrl;
      int            issues;
   } exp_t;
   exp_t        exp_q[$];
   logic [31:0] opa_q[$];
   logic [31:0] opb_q[$];

   // Shared divider model: 32-bit RISC-V semantics, programmable latency, same reset.
   logic        div_rdy_en;
   int          div_lat;
   logic        m_pend, m_vld;
   int          m_cnt;
   logic [31:0] m_res;
   logic        stray_vld;
   logic [31:0] stray_data;

   assign bus.div_ready_i     = div_rdy_en;
   assign bus.div_res_valid_i = m_vld | stray_vld;
   assign bus.div_res_i       = stray_vld ? stray_data : m_res;

   function automatic logic [31:0] div32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'b00: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'b10: return (b == 0) ? a : a % b;
         2'b01: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return $signed(a) / $signed(b);
         end
         default: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return $signed(a) % $signed(b);
         end
      endcase
   endfunction

   // Element reference computed natively at the element width.
   function automatic logic [31:0] ref_elem(input logic [1:0] op, input int sb, input logic [31:0] a, input logic [31:0] b);
      longint m, ua, ub, sa, sv, q, r;
      m  = (longint'(1) << sb) - 1;
      ua = longint'(a) & m;
      ub = longint'(b) & m;
      sa = ua;
      sv = ub;
      if (op[0]) begin
         if (ua[sb-1]) sa = ua - (longint'(1) << sb);
         if (ub[sb-1]) sv = ub - (longint'(1) << sb);
      end
      if (sv == 0) begin
         q = -1;
         r = sa;
      end else begin
         q = sa / sv;
         r = sa % sv;
      end
      return 32'((op[1] ? r : q) & m);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend <= 1'b0;
         m_vld  <= 1'b0;
         m_cnt  <= 0;
         m_res  <= '0;
      end else begin
         if (bus.div_valid_o && bus.div_ready_i) begin
            m_pend <= 1'b1;
            m_cnt  <= div_lat;
            m_res  <= div32(bus.div_op_o, bus.div_opa_o, bus.div_opb_o);
         end else if (m_pend) begin
            if (m_cnt == 0) begin
               m_vld  <= 1'b1;
               m_pend <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
         if (m_vld && bus.div_res_ready_o) m_vld <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (!rst && bus.div_valid_o && bus.div_ready_i) begin
         opa_q.push_back(bus.div_opa_o);
         opb_q.push_back(bus.div_opb_o);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [CW-1:0] ctrl, input logic [1:0] sew, input logic [1:0] op,
                       input logic [W-1:0] op1, input logic [W-1:0] op2,
                       input logic [NB-1:0] mask, input logic masked);
      exp_t x;
      int   sb, n, cnt;
      sb = (sew == 2'b00) ? 8 : (sew == 2'b01) ? 16 : 32;
      n  = W / sb;
      x.res    = '0;
      x.issues = 0;
      x.mask   = masked ? mask : '1;
      x.ctrl   = ctrl;
      for (int e = 0; e < n; e++) begin
         if (!masked || mask[e*sb/8]) begin
            x.issues++;
            x.res = x.res | (W'(ref_elem(op, sb, 32'(op2 >> (e*sb)), 32'(op1 >> (e*sb)))) << (e*sb));
         end
      end
      exp_q.push_back(x);
      bus.in_valid_i  = 1'b1;
      bus.in_ctrl_i   = ctrl;
      bus.in_sew_i    = sew;
      bus.in_op_i     = op;
      bus.in_op1_i    = op1;
      bus.in_op2_i    = op2;
      bus.in_mask_i   = mask;
      bus.in_masked_i = masked;
      cnt = 0;
      while (!bus.in_ready_o && cnt < 200) begin
         step();
         cnt++;
      end
      if (!bus.in_ready_o) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout in_ready_o=%0b required 1", bus.in_ready_o);
      end
      step();
      bus.in_valid_i = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      int cnt = 0;
      while (!bus.out_valid_o && cnt < 2000) begin
         step();
         cnt++;
      end
      ok = bus.out_valid_o;
   endtask

   task automatic release_out();
      bus.out_ready_i = 1'b1;
      step();
      bus.out_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (bus.in_ready_o !== 1'b1)      begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready_o); end
      checks++; if (bus.div_valid_o !== 1'b0)     begin errors++; $display("FAIL rst_div_valid got %b want 0", bus.div_valid_o); end
      checks++; if (bus.div_res_ready_o !== 1'b0) begin errors++; $display("FAIL rst_div_res_ready got %b want 0", bus.div_res_ready_o); end
      checks++; if (bus.out_valid_o !== 1'b0)     begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid_o); end
      checks++; if (bus.out_res_o !== '0)         begin errors++; $display("FAIL rst_out_res got %h want 0", bus.out_res_o); end
      checks++; if (bus.out_mask_o !== '0)        begin errors++; $display("FAIL rst_out_mask got %h want 0", bus.out_mask_o); end
      checks++; if (bus.out_ctrl_o !== '0)        begin errors++; $display("FAIL rst_out_ctrl got %h want 0", bus.out_ctrl_o); end
   endtask

   task automatic test_sew32_divu();
      exp_t x;
      bit   ok;
      opa_q.delete(); opb_q.delete();
      div_lat = 1;
      send(32'hC0DE_0001, 2'b10, 2'b00, 64'h00000005_00000003, 64'h00000064_0000000A, 8'hFF, 1'b0);
      wait_out(ok);
      x = exp_q.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL s32_out_timeout out_valid=%b want 1", bus.out_valid_o); end
      checks++; if (bus.out_res_o !== x.res) begin errors++; $display("FAIL s32_res_sb got %h want %h", bus.out_res_o, x.res); end
      checks++; if (bus.out_res_o !== 64'h00000014_00000003) begin errors++; $display("FAIL s32_res got %h want 0000001400000003", bus.out_res_o); end
      checks++; if (bus.out_mask_o !== 8'hFF) begin errors++; $display("FAIL s32_mask got %h want ff", bus.out_mask_o); end
      checks++; if (bus.out_ctrl_o !== 32'hC0DE_0001) begin errors++; $display("FAIL s32_ctrl got %h want c0de0001", bus.out_ctrl_o); end
      checks++; if (opa_q.size() !== 2) begin errors++; $display("FAIL s32_issues got %0d want 2", opa_q.size()); end
      if (opa_q.size() == 2) begin
         checks++; if (opa_q[0] !== 32'h0000_000A) begin errors++; $display("FAIL s32_opa0 got %h want 0000000a", opa_q[0]); end
         checks++; if (opa_q[1] !== 32'h0000_0064) begin errors++; $display("FAIL s32_opa1 got %h want 00000064", opa_q[1]); end
      end
      release_out();
   endtask

   task automatic test_sew8_div();
      exp_t x;
      bit   ok;
      opa_q.delete(); opb_q.delete();
      send(32'h0000_0008, 2'b00, 2'b01, 64'h01010101_01010103, 64'h01010101_010101F6, 8'hFF, 1'b0);
      wait_out(ok);
      x = exp_q.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL s8_out_timeout out_valid=%b want 1", bus.out_valid_o); end
      checks++; if (bus.out_res_o !== 64'h01010101_010101FD) begin errors++; $display("FAIL s8_res got %h want 01010101010101fd", bus.out_res_o); end
      checks++; if (bus.out_res_o !== x.res) begin errors++; $display("FAIL s8_res_sb got %h want %h", bus.out_res_o, x.res); end
      checks++; if (opa_q.size() !== 8) begin errors++; $display("FAIL s8_issues got %0d want 8", opa_q.size()); end
      if (opa_q.size() > 0) begin
         checks++; if (opa_q[0] !== 32'hFFFF_FFF6) begin errors++; $display("FAIL s8_opa0 got %h want fffffff6", opa_q[0]); end
         checks++; if (opb_q[0] !== 32'h0000_0003) begin errors++; $display("FAIL s8_opb0 got %h want 00000003", opb_q[0]); end
      end
      release_out();
   endtask

   task automatic test_sew16_remu_masked();
      exp_t x;
      bit   ok;
      opa_q.delete(); opb_q.delete();
      send(32'h0000_0016, 2'b01, 2'b10, 64'h0123_0456_0789_0ABC, 64'hFEDC_BA98_7654_3210, 8'h33, 1'b1);
      wait_out(ok);
      x = exp_q.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL s16_out_timeout out_valid=%b want 1", bus.out_valid_o); end
      checks++; if (bus.out_res_o !== x.res) begin errors++; $display("FAIL s16_res_sb got %h want %h", bus.out_res_o, x.res); end
      checks++; if (bus.out_res_o[31:16] !== 16'h0 || bus.out_res_o[63:48] !== 16'h0) begin errors++; $display("FAIL s16_skip_slots got %h want slots1,3 zero", bus.out_res_o); end
      checks++; if (bus.out_mask_o !== 8'h33) begin errors++; $display("FAIL s16_mask got %h want 33", bus.out_mask_o); end
      checks++; if (opa_q.size() !== 2) begin errors++; $display("FAIL s16_issues got %0d want 2", opa_q.size()); end
      release_out();
   endtask

   task automatic test_stall();
      exp_t x;
      bit   ok;
      div_rdy_en = 1'b0;
      send(32'h0000_5A11, 2'b10, 2'b00, 64'h00000007_00000002, 64'h00000015_00000009, 8'hFF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.div_valid_o !== 1'b1) begin errors++; $display("FAIL stall_div_valid c%0d got %b want 1", i, bus.div_valid_o); end
         checks++; if (bus.div_opa_o !== 32'h0000_0009) begin errors++; $display("FAIL stall_opa c%0d got %h want 00000009", i, bus.div_opa_o); end
         checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d got %b want 0", i, bus.in_ready_o); end
         step();
      end
      div_rdy_en = 1'b1;
      wait_out(ok);
      x = exp_q.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL stall_out_timeout out_valid=%b want 1", bus.out_valid_o); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.out_res_o !== 64'h00000003_00000004 || bus.out_res_o !== x.res) begin errors++; $display("FAIL hold_res c%0d got %h want 0000000300000004", i, bus.out_res_o); end
         checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid c%0d got %b want 1", i, bus.out_valid_o); end
         checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL hold_in_ready c%0d got %b want 0", i, bus.in_ready_o); end
         step();
      end
      bus.out_ready_i = 1'b1;
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL hs_in_ready got %b want 0", bus.in_ready_o); end
      step();
      bus.out_ready_i = 1'b0;
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL post_hs_in_ready got %b want 1", bus.in_ready_o); end
   endtask

   task automatic test_reset_wait();
      exp_t x;
      int   cnt = 0;
      div_lat = 20;
      send(32'hBAD0_0001, 2'b10, 2'b00, 64'h00000003_00000003, 64'h00000009_00000009, 8'hFF, 1'b0);
      while (!bus.div_res_ready_o && cnt < 50) begin
         step();
         cnt++;
      end
      checks++; if (bus.div_res_ready_o !== 1'b1) begin errors++; $display("FAIL rw_reach_wait got %b want 1", bus.div_res_ready_o); end
      x = exp_q.pop_front();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      div_lat = 1;
      step();
      checks++; if (bus.in_ready_o !== 1'b1)  begin errors++; $display("FAIL rw_in_ready got %b want 1", bus.in_ready_o); end
      checks++; if (bus.div_valid_o !== 1'b0) begin errors++; $display("FAIL rw_div_valid got %b want 0", bus.div_valid_o); end
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rw_out_valid got %b want 0", bus.out_valid_o); end
      checks++; if (bus.out_ctrl_o !== '0)    begin errors++; $display("FAIL rw_out_ctrl got %h want 0", bus.out_ctrl_o); end
      stray_data = 32'hDEAD_BEEF;
      stray_vld  = 1'b1;
      checks++; if (bus.div_res_ready_o !== 1'b0) begin errors++; $display("FAIL rw_res_ready got %b want 0", bus.div_res_ready_o); end
      step();
      stray_vld = 1'b0;
      step();
      checks++; if (bus.out_res_o !== '0)     begin errors++; $display("FAIL rw_stray_res got %h want 0", bus.out_res_o); end
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rw_stray_valid got %b want 0", bus.out_valid_o); end
      checks++; if (bus.in_ready_o !== 1'b1)  begin errors++; $display("FAIL rw_stray_in_ready got %b want 1", bus.in_ready_o); end
   endtask

   task automatic test_all_masked();
      exp_t x;
      opa_q.delete(); opb_q.delete();
      send(32'h0000_00AA, 2'b10, 2'b00, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 8'h00, 1'b1);
      x = exp_q.pop_front();
      checks++; if (bus.div_valid_o !== 1'b0) begin errors++; $display("FAIL am_div_valid0 got %b want 0", bus.div_valid_o); end
      step();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL am_early_valid got %b want 0", bus.out_valid_o); end
      checks++; if (bus.div_valid_o !== 1'b0) begin errors++; $display("FAIL am_div_valid1 got %b want 0", bus.div_valid_o); end
      step();
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL am_out_valid got %b want 1", bus.out_valid_o); end
      checks++; if (bus.out_res_o !== '0 || bus.out_res_o !== x.res) begin errors++; $display("FAIL am_res got %h want 0", bus.out_res_o); end
      checks++; if (bus.out_mask_o !== 8'h00) begin errors++; $display("FAIL am_mask got %h want 00", bus.out_mask_o); end
      checks++; if (opa_q.size() !== 0) begin errors++; $display("FAIL am_issues got %0d want 0", opa_q.size()); end
      release_out();
   endtask

   task automatic test_back_to_back();
      exp_t          x;
      bit            ok;
      logic [W-1:0]  op1, op2;
      logic [1:0]    sew, op;
      logic [NB-1:0] mask;
      logic          masked;
      for (int t = 0; t < 10; t++) begin
         sew    = 2'($urandom_range(0, 3));
         op     = 2'($urandom_range(0, 3));
         op1    = {$urandom(), $urandom()};
         op2    = {$urandom(), $urandom()};
         if ($urandom_range(0, 3) == 0) op1[15:0] = 16'h0;
         if ($urandom_range(0, 3) == 0) op2[31:24] = 8'h80;
         mask   = 8'($urandom());
         masked = 1'($urandom_range(0, 1));
         div_lat = $urandom_range(0, 3);
         opa_q.delete(); opb_q.delete();
         send(32'($urandom()), sew, op, op1, op2, mask, masked);
         wait_out(ok);
         x = exp_q.pop_front();
         checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout t%0d out_valid=%b want 1", t, bus.out_valid_o); end
         checks++; if (bus.out_res_o !== x.res) begin errors++; $display("FAIL b2b_res t%0d sew=%0d op=%0d got %h want %h", t, sew, op, bus.out_res_o, x.res); end
         checks++; if (bus.out_mask_o !== x.mask) begin errors++; $display("FAIL b2b_mask t%0d got %h want %h", t, bus.out_mask_o, x.mask); end
         checks++; if (bus.out_ctrl_o !== x.ctrl) begin errors++; $display("FAIL b2b_ctrl t%0d got %h want %h", t, bus.out_ctrl_o, x.ctrl); end
         checks++; if (opa_q.size() !== x.issues) begin errors++; $display("FAIL b2b_issues t%0d got %0d want %0d", t, opa_q.size(), x.issues); end
         release_out();
      end
   endtask

   initial begin
      bus.in_valid_i  = 1'b0;
      bus.in_ctrl_i   = '0;
      bus.in_sew_i    = '0;
      bus.in_op_i     = '0;
      bus.in_op1_i    = '0;
      bus.in_op2_i    = '0;
      bus.in_mask_i   = '0;
      bus.in_masked_i = 1'b0;
      bus.out_ready_i = 1'b0;
      div_rdy_en      = 1'b1;
      div_lat         = 1;
      stray_vld       = 1'b0;
      stray_data      = '0;
      rst             = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      test_reset();
      test_sew32_divu();
      test_sew8_div();
      test_sew16_remu_masked();
      test_stall();
      test_reset_wait();
      test_all_masked();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
